i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 7, data byte MSB index (byte = [DATA_WIDTH:0], 8 bits).
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 6, device address MSB index (address = [ADDRESS_WIDTH:0], 7 bits).
REQ-003 SHALL have parameter TARGET_ADDR, default 7'h50, own bus address.
REQ-004 SHALL have parameter Depth, default 16, register-file entries (power of two); pointer width = log2(Depth).
REQ-005 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port scl_in  input  1  bus SCL level, asynchronous to clk.
REQ-008 SHALL have port sda_in  input  1  bus SDA level, asynchronous to clk.
REQ-009 SHALL have port sda_oe  output  1  1 = pull SDA low (open drain), 0 = release.
REQ-010 SHALL have port wr_valid  output  1  one-cycle pulse when a data byte is written to the register file.
REQ-011 SHALL have port wr_addr  output  log2(Depth)  register index of that write.
REQ-012 SHALL have port wr_data  output  DATA_WIDTH+1  byte written.
REQ-013 SHALL have port busy  output  1  high from own-address match to STOP or restart.

Function
REQ-014 SHALL pass scl_in and sda_in through 2-flop synchronizers plus a history flop; all edge detection uses the synchronized values.
REQ-015 SHALL detect START as SDA falling while SCL high, and STOP as SDA rising while SCL high.
REQ-016 SHALL sample SDA on SCL rising edges and change sda_oe only on SCL falling edges, with at most 1 clk of delay after the detected edge.
REQ-017 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, with bit counter 0..7 shifting MSB first.
REQ-018 SHALL go to ADDR on START from any state, including a repeated START mid-transfer; the bit counter and shift register are cleared and the pointer is kept.
REQ-019 SHALL go to IDLE on STOP from any state, release sda_oe, and drop busy.
REQ-020 SHALL, in ADDR, on the 8th bit compare the 7 address bits with TARGET_ADDR: on a match, enter ADDR_ACK, drive ACK (sda_oe=1) for one SCL period and set busy; on a mismatch, enter IDLE with no ACK.
REQ-021 SHALL, after ADDR_ACK, go to PTR if R/W=0 (write) and to RDATA if R/W=1 (read).
REQ-022 SHALL, for the first write byte (PTR), load its low log2(Depth) bits as the pointer, ACK it, then go to WDATA.
REQ-023 SHALL, for each WDATA byte, store mem[ptr], pulse wr_valid with wr_addr/wr_data on the SCL rise of bit 8, ACK it, and increment ptr modulo Depth.
REQ-024 SHALL, in RDATA, drive mem[ptr] MSB first (sda_oe = ~bit), release SDA in RDATA_ACK, and sample the initiator ACK.
REQ-025 SHALL, in RDATA_ACK, increment ptr modulo Depth; an initiator ACK (SDA=0) loads the next byte, an initiator NACK goes to IDLE.
REQ-026 SHALL ignore SCL edges in IDLE, so traffic to other addresses has no effect.
REQ-027 SHALL wrap the pointer from Depth-1 to 0 on both read and write.

Reset
REQ-028 SHALL, with reset high at posedge clk, force state=IDLE, sda_oe=0, busy=0, wr_valid=0, wr_addr=0, wr_data=0, ptr=0, bit counter=0, all mem entries=0, and synchronizer flops=1 (bus idle high).
REQ-029 SHALL abandon a transfer when reset is asserted mid-transfer, release SDA within 1 clk, and wait for a new START after reset.

Structure
REQ-030 SHALL place the state enumeration, TARGET_ADDR default, and ACK/NACK constants in a shared package i2c_pkg, also used by the initiator.
REQ-031 SHALL implement the synchronizer and START/STOP/edge detection as one sub-module, i2c_bus_sync.

Verification
REQ-032 SHALL verify: START, 0xA0 (0x50+W), 0x03, 0x5A, STOP -> ACK on all three bytes, one wr_valid with wr_addr=3, wr_data=0x5A, mem[3]=0x5A.
REQ-033 SHALL verify: write ptr 0x0F then 0x11, 0x22 -> wr_addr 15 then 0, wrap confirmed, mem[0]=0x22.
REQ-034 SHALL verify: write ptr 0x03, repeated START, 0xA1, read 2 bytes (ACK, then NACK) -> SDA carries 0x5A then mem[4], and the target releases SDA after the NACK.
REQ-035 SHALL verify: START, 0x42 (address 0x21) -> no ACK (SDA high on 9th clock), busy stays 0, no wr_valid.
REQ-036 SHALL verify: reset asserted after 4 bits of a data byte -> sda_oe=0 and state IDLE next clk; a following full write succeeds.
REQ-037 SHALL verify: STOP injected mid-byte during WDATA -> IDLE, no wr_valid, mem unchanged.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, default bus address and ACK/NACK line levels.
// Used by both the target and the initiator.
package i2c_pkg;

  localparam logic [6:0] TARGET_ADDR_DEFAULT = 7'h50;
  localparam logic       ACK                 = 1'b0;
  localparam logic       NACK                = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and derives SCL edges plus START/STOP conditions.
// Each line runs through a meta flop, a sync flop and a history flop; all flops reset high (idle bus).
module i2c_bus_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  // bit 0 = meta, bit 1 = synchronized, bit 2 = history
  logic [2:0] r_scl;
  logic [2:0] r_sda;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scl <= 3'b111;
      r_sda <= 3'b111;
    end else begin
      r_scl <= {r_scl[1:0], i_scl};
      r_sda <= {r_sda[1:0], i_sda};
    end
  end

  assign o_sda      = r_sda[1];
  assign o_scl_rise =  r_scl[1] & ~r_scl[2];
  assign o_scl_fall = ~r_scl[1] &  r_scl[2];
  assign o_start    =  r_scl[1] &  r_scl[2] &  r_sda[2] & ~r_sda[1];
  assign o_stop     =  r_scl[1] &  r_scl[2] & ~r_sda[2] &  r_sda[1];

endmodule

// File: rtl/i2c_target.sv
// I2C target with a small register file: first write byte sets the pointer, later bytes
// write mem[ptr++]; reads return mem[ptr++]. Pointer wraps modulo Depth.
//
// state     | meaning
// IDLE      | not addressed, SCL edges ignored
// ADDR      | shifting in address + R/W
// ADDR_ACK  | driving ACK for our address
// PTR       | shifting in register pointer
// PTR_ACK   | driving ACK for pointer byte
// WDATA     | shifting in a write data byte
// WDATA_ACK | driving ACK for a data byte
// RDATA     | driving mem[ptr] MSB first
// RDATA_ACK | SDA released, sampling initiator ACK/NACK
module i2c_target
  import i2c_pkg::*;
#(
  parameter int                     DATA_WIDTH    = 7,
  parameter int                     ADDRESS_WIDTH = 6,
  parameter logic [ADDRESS_WIDTH:0] TARGET_ADDR   = TARGET_ADDR_DEFAULT,
  parameter int                     Depth         = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     scl_in,
  input  logic                     sda_in,
  output logic                     sda_oe,
  output logic                     wr_valid,
  output logic [$clog2(Depth)-1:0] wr_addr,
  output logic [DATA_WIDTH:0]      wr_data,
  output logic                     busy
);

  localparam int PW = $clog2(Depth);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_bus_sync u_sync (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_scl      (scl_in),
    .i_sda      (sda_in),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  i2c_state_e              r_state, w_state_nxt;
  logic [BW-1:0]           r_bit_cnt, w_bit_nxt;
  logic [DATA_WIDTH-1:0]   r_shift, w_shift_nxt;
  logic [PW-1:0]           r_ptr, w_ptr_nxt;
  logic                    r_phase, w_phase_nxt;
  logic                    r_rw, w_rw_nxt;
  logic                    r_sda_oe, w_sda_oe_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_wr_valid, w_wr_valid_nxt;
  logic [PW-1:0]           r_wr_addr, w_wr_addr_nxt;
  logic [DATA_WIDTH:0]     r_wr_data, w_wr_data_nxt;
  logic                    w_mem_we;
  logic [DATA_WIDTH:0]     r_mem [Depth];

  logic [DATA_WIDTH:0] w_byte;
  logic [DATA_WIDTH:0] w_mem_rd;
  logic                w_last;

  assign w_byte   = {r_shift, w_sda};
  assign w_mem_rd = r_mem[r_ptr];
  assign w_last   = (r_bit_cnt == BW'(DATA_WIDTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_ptr      <= '0;
      r_phase    <= 1'b0;
      r_rw       <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_ptr      <= w_ptr_nxt;
      r_phase    <= w_phase_nxt;
      r_rw       <= w_rw_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_wr_valid <= w_wr_valid_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      if (w_mem_we) r_mem[r_ptr] <= w_byte;
    end
  end

  // r_phase marks that the 9th (ACK) SCL rise has passed, so the next fall ends the ACK slot
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_nxt      = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_ptr_nxt      = r_ptr;
    w_phase_nxt    = r_phase;
    w_rw_nxt       = r_rw;
    w_sda_oe_nxt   = r_sda_oe;
    w_busy_nxt     = r_busy;
    w_wr_valid_nxt = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;
    w_mem_we       = 1'b0;

    if (w_start) begin
      w_state_nxt  = ADDR;
      w_bit_nxt    = '0;
      w_shift_nxt  = '0;
      w_phase_nxt  = 1'b0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_stop) begin
      w_state_nxt  = IDLE;
      w_bit_nxt    = '0;
      w_phase_nxt  = 1'b0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else begin
      case (r_state)
        ADDR, PTR, WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte[DATA_WIDTH-1:0];
            w_bit_nxt   = r_bit_cnt + BW'(1);
            if (w_last) begin
              w_bit_nxt   = '0;
              w_phase_nxt = 1'b0;
              case (r_state)
                ADDR: begin
                  if (w_byte[DATA_WIDTH -: ADDRESS_WIDTH+1] == TARGET_ADDR) begin
                    w_state_nxt = ADDR_ACK;
                    w_busy_nxt  = 1'b1;
                    w_rw_nxt    = w_byte[0];
                  end else begin
                    w_state_nxt = IDLE;
                  end
                end
                PTR: begin
                  w_ptr_nxt   = w_byte[PW-1:0];
                  w_state_nxt = PTR_ACK;
                end
                default: begin
                  w_mem_we       = 1'b1;
                  w_wr_valid_nxt = 1'b1;
                  w_wr_addr_nxt  = r_ptr;
                  w_wr_data_nxt  = w_byte;
                  w_ptr_nxt      = r_ptr + PW'(1);
                  w_state_nxt    = WDATA_ACK;
                end
              endcase
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_oe_nxt = ~ACK;
            end else begin
              w_phase_nxt  = 1'b0;
              w_sda_oe_nxt = 1'b0;
              if (r_state == ADDR_ACK && r_rw) begin
                w_state_nxt  = RDATA;
                w_shift_nxt  = w_mem_rd[DATA_WIDTH-1:0];
                w_sda_oe_nxt = ~w_mem_rd[DATA_WIDTH];
              end else if (r_state == ADDR_ACK) begin
                w_state_nxt = PTR;
              end else begin
                w_state_nxt = WDATA;
              end
            end
          end else if (w_scl_rise) begin
            w_phase_nxt = 1'b1;
          end
        end
        RDATA: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt = ~r_shift[DATA_WIDTH-1];
            w_shift_nxt  = {r_shift[DATA_WIDTH-2:0], 1'b0};
          end else if (w_scl_rise) begin
            w_bit_nxt = r_bit_cnt + BW'(1);
            if (w_last) begin
              w_bit_nxt   = '0;
              w_phase_nxt = 1'b0;
              w_state_nxt = RDATA_ACK;
            end
          end
        end
        RDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_oe_nxt = 1'b0;
            end else begin
              w_phase_nxt  = 1'b0;
              w_state_nxt  = RDATA;
              w_shift_nxt  = w_mem_rd[DATA_WIDTH-1:0];
              w_sda_oe_nxt = ~w_mem_rd[DATA_WIDTH];
            end
          end else if (w_scl_rise) begin
            w_ptr_nxt = r_ptr + PW'(1);
            if (w_sda == NACK) w_state_nxt = IDLE;
            else               w_phase_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe   = r_sda_oe;
  assign busy     = r_busy;
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: a bit-banged initiator drives the bus and results are
// compared against a plain array model of the register file.
module tb_i2c_target;

  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_line;
  logic       sda_oe, wr_valid, busy;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  assign sda_line = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target dut (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [7:0]  model_mem [16];
  logic [11:0] wr_q [$];
  logic [7:0]  tx_buf [16];
  logic [7:0]  rx_buf [16];

  always @(negedge clk) if (wr_valid) wr_q.push_back({wr_addr, wr_data});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    wait_clk(Q); sda_drv = 1'b1;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); sda_drv = 1'b0;
    wait_clk(Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(Q); sda_drv = 1'b0;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); sda_drv = 1'b1;
    wait_clk(2*Q);
  endtask

  task automatic wr_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      wait_clk(Q); sda_drv = b[i];
      wait_clk(Q); scl = 1'b1;
      wait_clk(2*Q); scl = 1'b0;
    end
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic acked);
    wr_bits(b, 8);
    wait_clk(Q); sda_drv = 1'b1;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); acked = (sda_line == 1'b0);
    wait_clk(Q); scl = 1'b0;
  endtask

  task automatic rd_byte(input logic send_ack, output logic [7:0] b);
    sda_drv = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_clk(2*Q); scl = 1'b1;
      wait_clk(Q); b[i] = sda_line;
      wait_clk(Q); scl = 1'b0;
    end
    wait_clk(Q); sda_drv = send_ack ? 1'b0 : 1'b1;
    wait_clk(Q); scl = 1'b1;
    wait_clk(2*Q); scl = 1'b0;
    wait_clk(Q); sda_drv = 1'b1;
  endtask

  task automatic xfer_write(input int p, input int n, output int acks);
    logic a;
    acks = 0;
    bus_start();
    wr_byte(8'hA0, a); acks += int'(a);
    wr_byte(8'(p), a); acks += int'(a);
    for (int k = 0; k < n; k++) begin
      wr_byte(tx_buf[k], a); acks += int'(a);
    end
    bus_stop();
  endtask

  task automatic xfer_read(input int p, input int n, output int acks);
    logic a;
    logic [7:0] b;
    acks = 0;
    bus_start();
    wr_byte(8'hA0, a); acks += int'(a);
    wr_byte(8'(p), a); acks += int'(a);
    bus_start();
    wr_byte(8'hA1, a); acks += int'(a);
    for (int k = 0; k < n; k++) begin
      rd_byte(k != n - 1, b);
      rx_buf[k] = b;
    end
    bus_stop();
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(2);
    model_clear();
    if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b want 0", sda_oe); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++;
    if (wr_valid !== 1'b0) $display("FAIL reset_wr_valid: got %b want 0", wr_valid); else pass_cnt++;
    total_cnt++;
    if (wr_addr !== 4'h0) $display("FAIL reset_wr_addr: got %h want 0", wr_addr); else pass_cnt++;
    total_cnt++;
    if (wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h want 00", wr_data); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_basic_write();
    logic a0, a1, a2;
    int base = wr_q.size();
    bus_start();
    wr_byte(8'hA0, a0);
    if (busy !== 1'b1) $display("FAIL basic_busy_after_addr: got %b want 1", busy); else pass_cnt++;
    total_cnt++;
    wr_byte(8'h03, a1);
    wr_byte(8'h5A, a2);
    bus_stop();
    model_mem[3] = 8'h5A;
    if ({a0, a1, a2} !== 3'b111) $display("FAIL basic_acks: got %b want 111", {a0, a1, a2}); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL basic_busy_after_stop: got %b want 0", busy); else pass_cnt++;
    total_cnt++;
    if (wr_q.size() - base !== 1) $display("FAIL basic_wr_count: got %0d want 1", wr_q.size() - base);
    else if (wr_q[base] !== {4'd3, 8'h5A}) $display("FAIL basic_wr_event: got %h want 35a", wr_q[base]);
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_wrap();
    int acks;
    int base = wr_q.size();
    tx_buf[0] = 8'h11;
    tx_buf[1] = 8'h22;
    xfer_write(15, 2, acks);
    model_mem[15] = 8'h11;
    model_mem[0]  = 8'h22;
    if (acks !== 4) $display("FAIL wrap_acks: got %0d want 4", acks); else pass_cnt++;
    total_cnt++;
    if (wr_q.size() - base !== 2) $display("FAIL wrap_wr_count: got %0d want 2", wr_q.size() - base);
    else if (wr_q[base] !== {4'd15, 8'h11} || wr_q[base+1] !== {4'd0, 8'h22})
      $display("FAIL wrap_wr_events: got %h %h want f11 022", wr_q[base], wr_q[base+1]);
    else pass_cnt++;
    total_cnt++;
    xfer_read(15, 2, acks);
    if (rx_buf[0] !== model_mem[15] || rx_buf[1] !== model_mem[0])
      $display("FAIL wrap_readback: got %h %h want %h %h", rx_buf[0], rx_buf[1], model_mem[15], model_mem[0]);
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_read();
    logic a0, a1, a2, line_hi;
    logic [7:0] b0, b1;
    bus_start();
    wr_byte(8'hA0, a0);
    wr_byte(8'h03, a1);
    bus_start();
    wr_byte(8'hA1, a2);
    if ({a0, a1, a2} !== 3'b111) $display("FAIL read_acks: got %b want 111", {a0, a1, a2}); else pass_cnt++;
    total_cnt++;
    rd_byte(1'b1, b0);
    rd_byte(1'b0, b1);
    if (b0 !== model_mem[3]) $display("FAIL read_byte0: got %h want %h", b0, model_mem[3]); else pass_cnt++;
    total_cnt++;
    if (b1 !== model_mem[4]) $display("FAIL read_byte1: got %h want %h", b1, model_mem[4]); else pass_cnt++;
    total_cnt++;
    wait_clk(2*Q); scl = 1'b1;
    wait_clk(Q); line_hi = sda_line;
    wait_clk(Q); scl = 1'b0;
    if (line_hi !== 1'b1 || sda_oe !== 1'b0)
      $display("FAIL read_release_after_nack: got line=%b oe=%b want line=1 oe=0", line_hi, sda_oe);
    else pass_cnt++;
    total_cnt++;
    bus_stop();
  endtask

  task automatic test_wrong_addr();
    logic a0, a1;
    int base = wr_q.size();
    bus_start();
    wr_byte(8'h42, a0);
    if (a0 !== 1'b0) $display("FAIL wrong_addr_ack: got acked=%b want 0", a0); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL wrong_addr_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++;
    wr_byte(8'h07, a1);
    wr_byte(8'h33, a1);
    bus_stop();
    if (wr_q.size() !== base) $display("FAIL wrong_addr_wr: got %0d events want 0", wr_q.size() - base); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_reset_mid();
    logic a0, a1;
    int acks;
    int base = wr_q.size();
    bus_start();
    wr_byte(8'hA0, a0);
    wr_byte(8'h06, a1);
    wr_bits(8'hC3, 4);
    if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy); else pass_cnt++;
    total_cnt++;
    reset = 1'b1;
    wait_clk(1);
    if (sda_oe !== 1'b0 || busy !== 1'b0)
      $display("FAIL rstmid_release: got oe=%b busy=%b want 0 0", sda_oe, busy);
    else pass_cnt++;
    total_cnt++;
    reset = 1'b0;
    model_clear();
    wr_bits(8'h30, 4);
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); sda_drv = 1'b1;
    wait_clk(4*Q);
    if (wr_q.size() !== base) $display("FAIL rstmid_no_write: got %0d events want 0", wr_q.size() - base); else pass_cnt++;
    total_cnt++;
    tx_buf[0] = 8'h77;
    xfer_write(5, 1, acks);
    model_mem[5] = 8'h77;
    if (acks !== 3) $display("FAIL rstmid_write_acks: got %0d want 3", acks); else pass_cnt++;
    total_cnt++;
    if (wr_q.size() - base !== 1) $display("FAIL rstmid_wr_count: got %0d want 1", wr_q.size() - base);
    else if (wr_q[base] !== {4'd5, 8'h77}) $display("FAIL rstmid_wr_event: got %h want 577", wr_q[base]);
    else pass_cnt++;
    total_cnt++;
    xfer_read(3, 3, acks);
    for (int k = 0; k < 3; k++) begin
      if (rx_buf[k] !== model_mem[3+k])
        $display("FAIL rstmid_readback[%0d]: got %h want %h", k, rx_buf[k], model_mem[3+k]);
      else pass_cnt++;
      total_cnt++;
    end
  endtask

  task automatic test_stop_mid();
    logic a0, a1;
    int acks;
    int base = wr_q.size();
    bus_start();
    wr_byte(8'hA0, a0);
    wr_byte(8'h09, a1);
    wr_bits(8'hE7, 4);
    bus_stop();
    if (busy !== 1'b0) $display("FAIL stopmid_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++;
    if (wr_q.size() !== base) $display("FAIL stopmid_no_write: got %0d events want 0", wr_q.size() - base); else pass_cnt++;
    total_cnt++;
    xfer_read(9, 1, acks);
    if (rx_buf[0] !== model_mem[9]) $display("FAIL stopmid_mem: got %h want %h", rx_buf[0], model_mem[9]); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_random();
    int p, n, acks, base, exp_acks;
    for (int it = 0; it < 8; it++) begin
      p = int'($urandom_range(0, 15));
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) tx_buf[k] = 8'($urandom);
      base = wr_q.size();
      xfer_write(p, n, acks);
      exp_acks = n + 2;
      if (acks !== exp_acks) $display("FAIL rand_write_acks[%0d]: got %0d want %0d", it, acks, exp_acks); else pass_cnt++;
      total_cnt++;
      if (wr_q.size() - base !== n) begin
        $display("FAIL rand_wr_count[%0d]: got %0d want %0d", it, wr_q.size() - base, n);
        total_cnt++;
      end else begin
        for (int k = 0; k < n; k++) begin
          if (wr_q[base+k] !== {4'((p + k) % 16), tx_buf[k]})
            $display("FAIL rand_wr_event[%0d.%0d]: got %h want %h", it, k, wr_q[base+k], {4'((p + k) % 16), tx_buf[k]});
          else pass_cnt++;
          total_cnt++;
        end
      end
      for (int k = 0; k < n; k++) model_mem[(p + k) % 16] = tx_buf[k];
      p = int'($urandom_range(0, 15));
      n = int'($urandom_range(1, 4));
      xfer_read(p, n, acks);
      for (int k = 0; k < n; k++) begin
        if (rx_buf[k] !== model_mem[(p + k) % 16])
          $display("FAIL rand_read[%0d.%0d]: got %h want %h", it, k, rx_buf[k], model_mem[(p + k) % 16]);
        else pass_cnt++;
        total_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_wrap();
    test_read();
    test_wrong_addr();
    test_reset_mid();
    test_stop_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
